// File: rtl/sync_cmd_exec.sv
// sync_cmd_exec
// Command consumer and pulse sequencer for the transmitter path. It polls the
// command memory, keeps the earliest future command armed, and when system
// time reaches its start it plays blank1, N pulse periods (with an optional
// frequency sweep on the NCO word) and blank2, then asks for the next command.
//
// Ports
//   CLK, rst_n        clock, asynchronous active-low reset
//   TIME              64-bit system time, +1 per CLK, may jump
//   DATA_WR           one-cycle strobe qualifying all *_z command fields
//   FREQ_z/FREQ_STEP_z/FREQ_RATE_z/TYPE_impulse_z   sweep description
//   TIME_START_z      execution time of the command
//   N_impuls_z, Interval_Ti_z, Interval_Tp_z        pulse count / width / period
//   Tblank1_z, Tblank2_z                            pre- / post-blank lengths
//   REQ_COMM          one-cycle poll request
//   NCO_FREQ          current frequency word
//   IMP, BLANK, BUSY  pulse gate, blanking gate, train in progress
//   CMD_DONE          one-cycle pulse after the last busy cycle
//   CMD_LATE          one-cycle pulse for a stale command
module sync_cmd_exec #(
  parameter int unsigned POLL_CYC = 48
) (
  input  logic        CLK,
  input  logic        rst_n,
  input  logic [63:0] TIME,
  input  logic        DATA_WR,
  input  logic [47:0] FREQ_z,
  input  logic [47:0] FREQ_STEP_z,
  input  logic [31:0] FREQ_RATE_z,
  input  logic [63:0] TIME_START_z,
  input  logic [15:0] N_impuls_z,
  input  logic [1:0]  TYPE_impulse_z,
  input  logic [31:0] Interval_Ti_z,
  input  logic [31:0] Interval_Tp_z,
  input  logic [31:0] Tblank1_z,
  input  logic [31:0] Tblank2_z,
  output logic        REQ_COMM,
  output logic [47:0] NCO_FREQ,
  output logic        IMP,
  output logic        BLANK,
  output logic        BUSY,
  output logic        CMD_DONE,
  output logic        CMD_LATE
);

  localparam int unsigned   PW          = (POLL_CYC > 1) ? $clog2(POLL_CYC) : 1;
  localparam logic [PW-1:0] POLL_RELOAD = PW'(POLL_CYC - 1);

  localparam logic [2:0] S_POLL   = 3'd0;
  localparam logic [2:0] S_ARMED  = 3'd1;
  localparam logic [2:0] S_BLANK1 = 3'd2;
  localparam logic [2:0] S_PULSE  = 3'd3;
  localparam logic [2:0] S_GAP    = 3'd4;
  localparam logic [2:0] S_BLANK2 = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  typedef struct packed {
    logic [63:0] start;
    logic [47:0] freq;
    logic [47:0] step;
    logic [31:0] rate;
    logic [15:0] n;
    logic [1:0]  mode;
    logic [31:0] ti;
    logic [31:0] tp;
    logic [31:0] tb1;
    logic [31:0] tb2;
  } cmd_t;

  cmd_t          armed, incoming;
  logic [2:0]    state, state_nxt;
  logic [31:0]   seg_cnt, seg_nxt;   // shared by blank segments and pulse periods
  logic [15:0]   n_left, n_nxt;      // periods still to run after the current one
  logic [31:0]   rate_cnt;
  logic [47:0]   nco;
  logic [PW-1:0] poll_cnt;
  logic          req, late_q;

  logic          in_poll, start_go, accept, stale;
  logic [31:0]   tp_eff, on_len, gap_len;
  logic [2:0]    period_entry, blank2_entry, pulses_entry, blank1_entry;
  logic          enter, per_end, per_start, first_per;

  assign incoming = '{start: TIME_START_z, freq: FREQ_z, step: FREQ_STEP_z,
                      rate: FREQ_RATE_z, n: N_impuls_z, mode: TYPE_impulse_z,
                      ti: Interval_Ti_z, tp: Interval_Tp_z,
                      tb1: Tblank1_z, tb2: Tblank2_z};

  assign in_poll  = (state == S_POLL) || (state == S_ARMED);
  assign start_go = (state == S_ARMED) && (TIME >= armed.start);
  // A start on this edge wins over a coincident command strobe.
  assign accept   = DATA_WR && in_poll && !start_go;
  assign stale    = (TIME_START_z <= TIME);

  // Period geometry; a pulse occupies the head of each period, gap the tail.
  assign tp_eff  = (armed.tp == 32'd0) ? 32'd1 : armed.tp;
  assign on_len  = (armed.ti < tp_eff) ? armed.ti : tp_eff;
  assign gap_len = tp_eff - on_len;

  // Zero-length segments are skipped by chaining to the next non-empty one.
  assign period_entry = (on_len != 32'd0)    ? S_PULSE  : S_GAP;
  assign blank2_entry = (armed.tb2 != 32'd0) ? S_BLANK2 : S_DONE;
  assign pulses_entry = (armed.n != 16'd0)   ? period_entry : blank2_entry;
  assign blank1_entry = (armed.tb1 != 32'd0) ? S_BLANK1 : pulses_entry;

  // NOTE: every combinational output gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    seg_nxt   = seg_cnt;
    n_nxt     = n_left;
    enter     = 1'b0;
    per_end   = 1'b0;
    case (state)
      S_POLL:   if (accept && !stale) state_nxt = S_ARMED;
      S_ARMED:  if (start_go) begin
                  state_nxt = blank1_entry;
                  enter     = 1'b1;
                  n_nxt     = armed.n - 16'd1;
                end
      S_BLANK1: if (seg_cnt == 32'd0) begin
                  state_nxt = pulses_entry;
                  enter     = 1'b1;
                  n_nxt     = armed.n - 16'd1;
                end else seg_nxt = seg_cnt - 32'd1;
      // With a gap, the counter leaves PULSE at gap_len; it only hits 0
      // inside PULSE when the period has no gap at all.
      S_PULSE:  if (seg_cnt == 32'd0) per_end = 1'b1;
                else begin
                  seg_nxt = seg_cnt - 32'd1;
                  if (seg_cnt == gap_len) state_nxt = S_GAP;
                end
      S_GAP:    if (seg_cnt == 32'd0) per_end = 1'b1;
                else seg_nxt = seg_cnt - 32'd1;
      S_BLANK2: if (seg_cnt == 32'd0) state_nxt = S_DONE;
                else seg_nxt = seg_cnt - 32'd1;
      S_DONE:   state_nxt = S_POLL;
      default:  state_nxt = S_POLL;
    endcase

    if (per_end) begin
      enter = 1'b1;
      if (n_left == 16'd0) state_nxt = blank2_entry;
      else begin
        state_nxt = period_entry;
        n_nxt     = n_left - 16'd1;
      end
    end

    per_start = enter && ((state_nxt == S_PULSE) || (state_nxt == S_GAP));
    first_per = per_start && !per_end;

    // Segment counters are loaded with length-1 and run down to 0.
    if (enter) begin
      case (state_nxt)
        S_BLANK1:      seg_nxt = armed.tb1 - 32'd1;
        S_BLANK2:      seg_nxt = armed.tb2 - 32'd1;
        S_PULSE, S_GAP: seg_nxt = tp_eff - 32'd1;
        default:       ;
      endcase
    end
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // sees the pre-edge values of its neighbours, as the hardware does.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_POLL;
      seg_cnt  <= '0;
      n_left   <= '0;
      rate_cnt <= '0;
      nco      <= '0;
      poll_cnt <= '0;
      req      <= 1'b0;
      late_q   <= 1'b0;
      // NOTE: the armed command is a plain register bank, cleared on reset so
      // nothing left over from before the reset can ever be started.
      armed    <= '0;
    end else begin
      state   <= state_nxt;
      seg_cnt <= seg_nxt;
      n_left  <= n_nxt;
      req     <= 1'b0;
      late_q  <= 1'b0;

      // Poll timer: request at 0, then reload; DONE rearms an immediate poll.
      if (state == S_DONE) poll_cnt <= '0;
      else if (in_poll) begin
        if (poll_cnt == '0) begin
          poll_cnt <= POLL_RELOAD;
          req      <= !start_go;
        end else poll_cnt <= poll_cnt - 1'b1;
      end

      // Earliest start wins while armed; ties replace the armed command.
      if (accept) begin
        if (stale) late_q <= 1'b1;
        else if ((state == S_POLL) || (TIME_START_z <= armed.start)) armed <= incoming;
      end

      // Sweep: reload on the first period (every period in mode 3), otherwise
      // step every `rate` cycles spent in PULSE/GAP, modulo 2^48.
      if (per_start && (first_per || (armed.mode == 2'd3))) begin
        nco      <= armed.freq;
        rate_cnt <= armed.rate - 32'd1;
      end else if (((state == S_PULSE) || (state == S_GAP)) && (armed.rate != 32'd0)) begin
        if (rate_cnt == 32'd0) begin
          rate_cnt <= armed.rate - 32'd1;
          case (armed.mode)
            2'd1, 2'd3: nco <= nco + armed.step;
            2'd2:       nco <= nco - armed.step;
            default:    ;
          endcase
        end else rate_cnt <= rate_cnt - 32'd1;
      end
    end
  end

  assign REQ_COMM = req;
  assign CMD_LATE = late_q;
  assign NCO_FREQ = nco;
  assign IMP      = (state == S_PULSE);
  assign BLANK    = (state == S_BLANK1) || (state == S_BLANK2);
  assign BUSY     = (state == S_BLANK1) || (state == S_PULSE) ||
                    (state == S_GAP)    || (state == S_BLANK2);
  assign CMD_DONE = (state == S_DONE);

endmodule

// File: tb/tb_sync_cmd_exec.sv
// tb_sync_cmd_exec
// Directed checks of reset, polling, the reference pulse train, sweep wrap,
// stale / replacement handling, time jumps, empty commands and mid-train
// reset, followed by random commands compared with a closed-form model of
// the pulse schedule and sweep.
module tb_sync_cmd_exec;

  typedef struct {
    logic [63:0] start;
    logic [47:0] freq;
    logic [47:0] step;
    logic [31:0] rate;
    logic [15:0] n;
    logic [1:0]  mode;
    logic [31:0] ti;
    logic [31:0] tp;
    logic [31:0] tb1;
    logic [31:0] tb2;
  } cmd_t;

  logic        CLK;
  logic        rst_n;
  logic [63:0] TIME;
  logic        DATA_WR;
  logic [47:0] FREQ_z, FREQ_STEP_z;
  logic [31:0] FREQ_RATE_z;
  logic [63:0] TIME_START_z;
  logic [15:0] N_impuls_z;
  logic [1:0]  TYPE_impulse_z;
  logic [31:0] Interval_Ti_z, Interval_Tp_z, Tblank1_z, Tblank2_z;
  logic        REQ_COMM, IMP, BLANK, BUSY, CMD_DONE, CMD_LATE;
  logic [47:0] NCO_FREQ;

  int checks = 0;
  int errors = 0;

  sync_cmd_exec #(.POLL_CYC(48)) dut (
    .CLK(CLK), .rst_n(rst_n), .TIME(TIME), .DATA_WR(DATA_WR),
    .FREQ_z(FREQ_z), .FREQ_STEP_z(FREQ_STEP_z), .FREQ_RATE_z(FREQ_RATE_z),
    .TIME_START_z(TIME_START_z), .N_impuls_z(N_impuls_z),
    .TYPE_impulse_z(TYPE_impulse_z), .Interval_Ti_z(Interval_Ti_z),
    .Interval_Tp_z(Interval_Tp_z), .Tblank1_z(Tblank1_z), .Tblank2_z(Tblank2_z),
    .REQ_COMM(REQ_COMM), .NCO_FREQ(NCO_FREQ), .IMP(IMP), .BLANK(BLANK),
    .BUSY(BUSY), .CMD_DONE(CMD_DONE), .CMD_LATE(CMD_LATE)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the edge, and TIME
  // advances there so each cycle carries a single TIME value.
  task automatic step();
    @(posedge CLK);
    #1;
    TIME = TIME + 64'd1;
  endtask

  task automatic send_cmd(input cmd_t c);
    FREQ_z         = c.freq;
    FREQ_STEP_z    = c.step;
    FREQ_RATE_z    = c.rate;
    TIME_START_z   = c.start;
    N_impuls_z     = c.n;
    TYPE_impulse_z = c.mode;
    Interval_Ti_z  = c.ti;
    Interval_Tp_z  = c.tp;
    Tblank1_z      = c.tb1;
    Tblank2_z      = c.tb2;
    DATA_WR        = 1'b1;
    step();
    DATA_WR        = 1'b0;
  endtask

  function automatic cmd_t mk(input logic [63:0] s, input logic [31:0] tb1,
                              input logic [15:0] n, input logic [31:0] ti,
                              input logic [31:0] tp, input logic [31:0] tb2,
                              input logic [47:0] f, input logic [47:0] st,
                              input logic [31:0] r, input logic [1:0] m);
    cmd_t c;
    c.start = s; c.tb1 = tb1; c.n = n; c.ti = ti; c.tp = tp; c.tb2 = tb2;
    c.freq = f; c.step = st; c.rate = r; c.mode = m;
    return c;
  endfunction

  function automatic longint period_of(input cmd_t c);
    return (c.tp == 32'd0) ? 64'sd1 : longint'(c.tp);
  endfunction

  function automatic longint total_of(input cmd_t c);
    return longint'(c.tb1) + longint'(c.n) * period_of(c) + longint'(c.tb2);
  endfunction

  // Expected {BUSY, IMP, BLANK, CMD_DONE} in the cycle t after the start edge.
  function automatic logic [3:0] model_gates(input cmd_t c, input longint t);
    longint tb1, tp, on, body;
    logic busy, imp, blank, done;
    tb1   = longint'(c.tb1);
    tp    = period_of(c);
    on    = (longint'(c.ti) < tp) ? longint'(c.ti) : tp;
    body  = longint'(c.n) * tp;
    busy  = (t >= 1) && (t <= total_of(c));
    blank = busy && ((t <= tb1) || (t > tb1 + body));
    imp   = busy && !blank && (((t - tb1 - 1) % tp) < on);
    done  = (t == total_of(c) + 1);
    return {busy, imp, blank, done};
  endfunction

  // Expected NCO word p cycles into the pulse section (p = 0 is the first).
  function automatic logic [47:0] model_nco(input cmd_t c, input longint p);
    longint      k;
    logic [47:0] steps;
    k = (c.mode == 2'd3) ? (p % period_of(c)) : p;
    steps = (c.rate == 32'd0) ? 48'd0 : 48'(k / longint'(c.rate));
    case (c.mode)
      2'd1, 2'd3: return c.freq + c.step * steps;
      2'd2:       return c.freq - c.step * steps;
      default:    return c.freq;
    endcase
  endfunction

  // Runs until two cycles past CMD_DONE, checking every cycle against the model.
  task automatic run_and_check(input cmd_t c, input string tag);
    longint      t;
    logic [3:0]  g;
    while (longint'(TIME) <= longint'(c.start) + total_of(c) + 2) begin
      t = longint'(TIME) - longint'(c.start);
      g = model_gates(c, t);
      check($sformatf("%s t=%0d gates", tag, t), {60'd0, BUSY, IMP, BLANK, CMD_DONE}, {60'd0, g});
      if (t > longint'(c.tb1) && t <= longint'(c.tb1) + longint'(c.n) * period_of(c))
        check($sformatf("%s t=%0d nco", tag, t), {16'd0, NCO_FREQ},
              {16'd0, model_nco(c, t - longint'(c.tb1) - 1)});
      step();
    end
  endtask

  initial begin
    cmd_t        c;
    logic [63:0] s, tv;
    logic [47:0] en;

    rst_n = 1'b0; TIME = 64'd0; DATA_WR = 1'b0;
    c = mk(64'd0, 0, 0, 0, 0, 0, 48'd0, 48'd0, 0, 2'd0);
    FREQ_z = '0; FREQ_STEP_z = '0; FREQ_RATE_z = '0; TIME_START_z = '0;
    N_impuls_z = '0; TYPE_impulse_z = '0; Interval_Ti_z = '0; Interval_Tp_z = '0;
    Tblank1_z = '0; Tblank2_z = '0;

    // Reset state
    step(); step();
    check("reset outputs", {57'd0, REQ_COMM, IMP, BLANK, BUSY, CMD_DONE, CMD_LATE, 1'b0}, 64'd0);
    check("reset nco", {16'd0, NCO_FREQ}, 64'd0);
    rst_n = 1'b1;

    // Poll cadence: first request on the first edge, then every 48 cycles
    for (int i = 1; i <= 97; i++) begin
      step();
      check($sformatf("poll cycle %0d", i), {63'd0, REQ_COMM},
            {63'd0, (i == 1) || (i == 49) || (i == 97)});
    end
    check("idle outputs", {59'd0, IMP, BLANK, BUSY, CMD_DONE, CMD_LATE}, 64'd0);

    // Reference train at TIME=1000, S=1100
    TIME = 64'd1000;
    send_cmd(mk(64'd1100, 3, 2, 2, 5, 4, 48'd100, 48'd7, 0, 2'd0));
    while (TIME <= 64'd1119) begin
      tv = TIME;
      check($sformatf("ref T=%0d blank", tv), {63'd0, BLANK},
            {63'd0, (tv >= 1101 && tv <= 1103) || (tv >= 1114 && tv <= 1117)});
      check($sformatf("ref T=%0d imp", tv), {63'd0, IMP},
            {63'd0, (tv >= 1104 && tv <= 1105) || (tv >= 1109 && tv <= 1110)});
      check($sformatf("ref T=%0d busy", tv), {63'd0, BUSY}, {63'd0, tv >= 1101 && tv <= 1117});
      check($sformatf("ref T=%0d done", tv), {63'd0, CMD_DONE}, {63'd0, tv == 1118});
      if (tv == 64'd1104) check("ref nco", {16'd0, NCO_FREQ}, 64'd100);
      step();
    end

    // Mode 1 sweep wrapping modulo 2^48
    s = TIME + 64'd5;
    send_cmd(mk(s, 0, 1, 4, 9, 0, 48'hFFFF_FFFF_FFFF, 48'd2, 3, 2'd1));
    while (TIME < s + 64'd1) step();
    for (int k = 1; k <= 9; k++) begin
      en = (k <= 3) ? 48'hFFFF_FFFF_FFFF : ((k <= 6) ? 48'd1 : 48'd3);
      check($sformatf("wrap k=%0d nco", k), {16'd0, NCO_FREQ}, {16'd0, en});
      step();
    end
    check("wrap done", {63'd0, CMD_DONE}, 64'd1);
    step(); step();

    // Replacement while armed: 4000 replaces 5000, 6000 is ignored
    TIME = 64'd3000;
    send_cmd(mk(64'd5000, 1, 0, 0, 0, 0, 48'd0, 48'd0, 0, 2'd0));
    send_cmd(mk(64'd4000, 2, 0, 0, 0, 0, 48'd0, 48'd0, 0, 2'd0));
    send_cmd(mk(64'd6000, 3, 0, 0, 0, 0, 48'd0, 48'd0, 0, 2'd0));
    TIME = 64'd3990;
    while (TIME <= 64'd4005) begin
      tv = TIME;
      check($sformatf("replace T=%0d", tv), {61'd0, BUSY, BLANK, CMD_DONE},
            {61'd0, tv >= 4001 && tv <= 4002, tv >= 4001 && tv <= 4002, tv == 4003});
      step();
    end

    // Backward time jump while armed at 5000, plus a stale command in ARMED
    send_cmd(mk(64'd5000, 1, 0, 0, 0, 0, 48'd0, 48'd0, 0, 2'd0));
    TIME = 64'd4990;
    step(); step();
    send_cmd(mk(64'd4000, 0, 0, 0, 0, 0, 48'd0, 48'd0, 0, 2'd0));
    check("late in armed", {63'd0, CMD_LATE}, 64'd1);
    step();
    check("late pulse width", {63'd0, CMD_LATE}, 64'd0);
    TIME = 64'd100;
    for (int i = 0; i < 30; i++) begin
      check($sformatf("jump wait %0d", i), {63'd0, BUSY}, 64'd0);
      step();
    end
    TIME = 64'd4995;
    while (TIME <= 64'd5003) begin
      tv = TIME;
      check($sformatf("jump T=%0d", tv), {62'd0, BLANK, CMD_DONE},
            {62'd0, tv == 5001, tv == 5002});
      step();
    end

    // Stale command in POLL: CMD_LATE, nothing armed
    send_cmd(mk(TIME, 1, 0, 0, 0, 0, 48'd0, 48'd0, 0, 2'd0));
    check("late in poll", {63'd0, CMD_LATE}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("late stays poll %0d", i), {62'd0, BUSY, CMD_LATE}, 64'd0);
    end

    // Empty command: CMD_DONE the cycle after the start edge
    s = TIME + 64'd3;
    send_cmd(mk(s, 0, 0, 3, 3, 0, 48'd5, 48'd0, 0, 2'd0));
    while (TIME <= s + 64'd2) begin
      tv = TIME;
      check($sformatf("empty T+%0d", tv - s), {60'd0, BUSY, IMP, BLANK, CMD_DONE},
            {63'd0, tv == s + 64'd1});
      step();
    end

    // Reset in the middle of a pulse
    s = TIME + 64'd2;
    send_cmd(mk(s, 0, 3, 5, 6, 0, 48'h123, 48'd0, 0, 2'd0));
    while (TIME < s + 64'd2) step();
    check("mid pulse imp", {63'd0, IMP}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset gates", {61'd0, IMP, BLANK, BUSY}, 64'd0);
    check("async reset nco", {16'd0, NCO_FREQ}, 64'd0);
    #1 rst_n = 1'b1;
    step();
    check("post reset poll", {62'd0, REQ_COMM, CMD_DONE}, 64'd2);
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("no done after reset %0d", i), {62'd0, BUSY, CMD_DONE}, 64'd0);
    end

    // Random commands against the model
    for (int r = 0; r < 14; r++) begin
      c = mk(TIME + 64'($urandom_range(2, 6)),
             32'($urandom_range(0, 4)), 16'($urandom_range(0, 3)),
             32'($urandom_range(0, 6)), 32'($urandom_range(0, 6)),
             32'($urandom_range(0, 4)),
             {16'($urandom), 32'($urandom)}, {16'($urandom), 32'($urandom)},
             32'($urandom_range(0, 4)), 2'($urandom_range(0, 3)));
      send_cmd(c);
      run_and_check(c, $sformatf("rand%0d m%0d", r, c.mode));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sync_cmd_exec.md
# sync_cmd_exec

Command consumer and pulse sequencer at the synchronization end of the command-memory interface. Polls the command memory with `REQ_COMM`, captures the strobed command fields on `DATA_WR`, and arms the earliest future command. When system time reaches `TIME_START` it runs the pulse train: blank, N pulses with an optional frequency sweep, blank. It drives the NCO frequency word and the pulse/blank gates for the transmitter path.

## Interface
- `POLL_CYC`, 48: cycles between `REQ_COMM` polls (1 µs at 48 MHz); minimum 4.
- `CLK`  in  1  system clock, 48 MHz.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `TIME`  in  64  system time; +1 per CLK; may jump either way on time re-set.
- `DATA_WR`  in  1  command-valid strobe, 1 cycle, all `*_z` fields valid in that cycle.
- `FREQ_z` / `FREQ_STEP_z`  in  48 each  start frequency word / sweep step.
- `FREQ_RATE_z`  in  32  cycles between sweep steps; 0 = no stepping.
- `TIME_START_z`  in  64  execution time.
- `N_impuls_z`  in  16  pulse count.
- `TYPE_impulse_z`  in  2  sweep mode.
- `Interval_Ti_z` / `Interval_Tp_z`  in  32 each  pulse width / pulse period, cycles.
- `Tblank1_z` / `Tblank2_z`  in  32 each  pre- / post-blank length, cycles.
- `REQ_COMM`  out  1  1-cycle request for the next command.
- `NCO_FREQ`  out  48  current frequency word.
- `IMP`  out  1  pulse gate.
- `BLANK`  out  1  blanking gate.
- `BUSY`  out  1  high in BLANK1, PULSE, GAP, BLANK2.
- `CMD_DONE`  out  1  1-cycle pulse when a command finishes.
- `CMD_LATE`  out  1  1-cycle pulse when a received command is stale or late.

## Operation
- States: POLL, ARMED, BLANK1, PULSE, GAP, BLANK2, DONE. Reset enters POLL.
- Poll counter in POLL and ARMED counts `POLL_CYC-1`..0. `REQ_COMM`=1 for the cycle at 0, then the counter reloads.
  - Reset loads the counter with 0, so the first request comes on the first edge after reset release.
  - DONE→POLL also loads 0.
- `DATA_WR` is accepted in POLL/ARMED in any cycle; it is ignored in all other states.
  - If `TIME_START_z` ≤ `TIME`: pulse `CMD_LATE`, discard, state unchanged.
  - In POLL: latch all fields into the armed register, go to ARMED.
  - In ARMED: replace the armed command only if the new `TIME_START_z` ≤ armed start. Otherwise discard silently.
- ARMED→BLANK1 when `TIME` ≥ armed start. A backward time jump just keeps waiting.
- BLANK1: `BLANK`=1 for Tblank1 cycles. Tblank1=0 skips straight to PULSE/BLANK2 with no BLANK cycle.
- PULSE/GAP, repeated N times:
  - Period Tp' = max(Tp,1). `IMP`=1 for the first min(Ti,Tp') cycles of each period, GAP for the rest.
  - Ti=0 gives `IMP` never high, but periods still elapse.
  - N=0 goes directly to BLANK2.
- BLANK2: `BLANK`=1 for Tblank2 cycles (0 = skip). Then DONE: `CMD_DONE`=1 for one cycle, then POLL.
- `NCO_FREQ` loads FREQ on the first pulse start. The rate counter runs only during PULSE/GAP. Every FREQ_RATE cycles a step is applied, by mode:
  - 0: no step.
  - 1: `NCO_FREQ` += FREQ_STEP.
  - 2: `NCO_FREQ` −= FREQ_STEP.
  - 3: as mode 1, but reload FREQ and restart the rate counter at each pulse start.
- Step arithmetic is modulo 2^48 (wrap, no saturation). `NCO_FREQ` holds its last value after DONE until the next command loads it.

## Timing
- Reset (async, immediate): `REQ_COMM`, `IMP`, `BLANK`, `BUSY`, `CMD_DONE`, `CMD_LATE` = 0; `NCO_FREQ`=0; armed register cleared.
  - Reset asserted mid-train drops `IMP`/`BLANK` at once, with no `CMD_DONE`.
- Edge at which `TIME`==S is sampled in ARMED: `BLANK` (or `IMP` if Tblank1=0) is high in the following cycle.
- Segment lengths are exact cycle counts.
  - Total `BUSY` time = Tblank1 + N·Tp' + Tblank2 cycles.
  - `CMD_DONE` fires in the cycle after the last `BUSY` cycle.
- Edge cases:
  - `DATA_WR` coincident with the ARMED start condition: start wins and the new command is ignored.
  - `DATA_WR` coincident with `REQ_COMM`: accepted normally.
- Expected writer response to `REQ_COMM`: `DATA_WR` within 2–3 cycles, well inside `POLL_CYC`. No response is harmless; the block re-polls.
- All 32-bit down-counters are loaded with value−1 and end at 0. No overflow is possible.

## Test plan
- Reset release → `REQ_COMM` on cycle 1, then every 48 cycles; all other outputs 0.
- `TIME`=1000, `DATA_WR` with S=1100, Tb1=3, N=2, Ti=2, Tp=5, Tb2=4, FREQ=100, mode 0 → `BLANK` cycles 1101–1103, `IMP` 1104–1105 and 1109–1110, `BLANK` 1114–1117, `CMD_DONE` 1118.
- Mode 1, FREQ=2^48−1, STEP=2, RATE=3, N=1, Tp=9 → `NCO_FREQ` = 2^48−1, then 1, then 3, at 3-cycle spacing.
- `DATA_WR` with S ≤ `TIME` → `CMD_LATE` 1 cycle, state stays POLL.
  - In ARMED (S=5000), a new S=4000 replaces the armed command; a new S=6000 is ignored.
- `TIME` jumps from 4990 to 100 while armed at S=5000 → no start until `TIME` reaches 5000.
- Tb1=Tb2=0, N=0 → no `IMP`/`BLANK`, `CMD_DONE` the cycle after start. Reset mid-PULSE → `IMP`=0 immediately, no `CMD_DONE`.
